// File: rtl/ecap5_dproc_pkg.sv
// Shared constants for the ECAP5-DPROC pipeline control blocks.
package ecap5_dproc_pkg;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

endpackage

// File: rtl/hazard_down_ctr.sv
// Loadable down counter that saturates at zero; clear beats load beats decrement.
module hazard_down_ctr #(
   parameter int W = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: redirect discard window and load-use stall/bubble.
// Optional hazard cycle counters enabled by defining HAZARD_PERF_CTR_EN.
module hazard_ctrl
   import ecap5_dproc_pkg::*;
#(
   parameter int DISCARD_DEPTH = 2,
   parameter int LOAD_LATENCY  = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  branch_i,
   input  logic                  trap_i,
   input  logic [REG_ADDR_W-1:0] dec_rs1_i,
   input  logic [REG_ADDR_W-1:0] dec_rs2_i,
   input  logic                  dec_rs1_used_i,
   input  logic                  dec_rs2_used_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic                  ex_load_i,
   output logic                  stall_o,
   output logic                  bubble_o,
   output logic                  control_discard_o
`ifdef HAZARD_PERF_CTR_EN
   ,
   output logic [31:0]           stall_cnt_o,
   output logic [31:0]           discard_cnt_o
`endif
);

   localparam int DISC_W  = $clog2(DISCARD_DEPTH + 1);
   // A single-cycle load latency never needs the counter, but keep it one bit wide.
   localparam int STALL_W = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;
   localparam logic [DISC_W-1:0]  DISC_LOAD  = DISC_W'(DISCARD_DEPTH);
   localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(LOAD_LATENCY - 1);

   logic               redirect;
   logic               lu;
   logic               lu_q;
   logic               stall_load;
   logic               stall_clr;
   logic [DISC_W-1:0]  discard_ctr_q;
   logic [STALL_W-1:0] stall_ctr_q;

   assign redirect = branch_i | trap_i;

   assign lu = ex_load_i & (ex_rd_i != REG_X0) &
               ((dec_rs1_used_i & (dec_rs1_i == ex_rd_i)) |
                (dec_rs2_used_i & (dec_rs2_i == ex_rd_i)));

   assign lu_q = lu & ~control_discard_o & ~redirect;

   assign control_discard_o = (discard_ctr_q != '0);

   // The stalled instruction is thrown away by a redirect, so drop its remaining stall.
   assign stall_clr  = redirect | control_discard_o;
   assign stall_load = lu_q & (stall_ctr_q == '0);

   assign stall_o  = (lu_q | (stall_ctr_q != '0)) & ~redirect & ~control_discard_o;
   assign bubble_o = stall_o;

   hazard_down_ctr #(.W(DISC_W)) u_discard_ctr (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (1'b0),
      .load_i     (redirect),
      .load_val_i (DISC_LOAD),
      .cnt_o      (discard_ctr_q)
   );

   hazard_down_ctr #(.W(STALL_W)) u_stall_ctr (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (stall_clr),
      .load_i     (stall_load),
      .load_val_i (STALL_LOAD),
      .cnt_o      (stall_ctr_q)
   );

`ifdef HAZARD_PERF_CTR_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;
   logic [31:0] discard_cnt_q;
   logic [31:0] discard_cnt_d;

   assign stall_cnt_d   = stall_cnt_q + 32'(stall_o);
   assign discard_cnt_d = discard_cnt_q + 32'(control_discard_o);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q   <= '0;
         discard_cnt_q <= '0;
      end else begin
         stall_cnt_q   <= stall_cnt_d;
         discard_cnt_q <= discard_cnt_d;
      end
   end

   assign stall_cnt_o   = stall_cnt_q;
   assign discard_cnt_o = discard_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with DISCARD_DEPTH=3, LOAD_LATENCY=2.
module tb_hazard_ctrl;

   localparam int DD = 3;
   localparam int LL = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       branch = 1'b0;
   logic       trap = 1'b0;
   logic [4:0] rs1 = '0;
   logic [4:0] rs2 = '0;
   logic       rs1_used = 1'b0;
   logic       rs2_used = 1'b0;
   logic [4:0] ex_rd = '0;
   logic       ex_load = 1'b0;
   logic       stall;
   logic       bubble;
   logic       discard;
`ifdef HAZARD_PERF_CTR_EN
   logic [31:0] stall_cnt;
   logic [31:0] discard_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.DISCARD_DEPTH(DD), .LOAD_LATENCY(LL)) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .branch_i          (branch),
      .trap_i            (trap),
      .dec_rs1_i         (rs1),
      .dec_rs2_i         (rs2),
      .dec_rs1_used_i    (rs1_used),
      .dec_rs2_used_i    (rs2_used),
      .ex_rd_i           (ex_rd),
      .ex_load_i         (ex_load),
      .stall_o           (stall),
      .bubble_o          (bubble),
      .control_discard_o (discard)
`ifdef HAZARD_PERF_CTR_EN
      ,
      .stall_cnt_o       (stall_cnt),
      .discard_cnt_o     (discard_cnt)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      branch = 0; trap = 0; rs1 = 0; rs2 = 0;
      rs1_used = 0; rs2_used = 0; ex_rd = 0; ex_load = 0;
   endtask

   // Load in execute writing x5, decode reads x5 through rs2.
   task automatic hazard_rs2();
      ex_load = 1; ex_rd = 5; rs2 = 5; rs2_used = 1; rs1 = 3; rs1_used = 1;
   endtask

   task automatic test_reset();
      rst = 1; hazard_rs2(); branch = 1;
      step(); step(); step();
      rst = 0; idle();
      #1;
      vectors++;
      if (discard !== 1'b0) begin miscompares++; $display("FAIL reset_discard got=%b exp=0", discard); end
      vectors++;
      if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got=%b exp=0", stall); end
      vectors++;
      if (bubble !== 1'b0) begin miscompares++; $display("FAIL reset_bubble got=%b exp=0", bubble); end
`ifdef HAZARD_PERF_CTR_EN
      vectors++;
      if (stall_cnt !== 32'd0 || discard_cnt !== 32'd0) begin
         miscompares++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", stall_cnt, discard_cnt);
      end
`endif
      step();
   endtask

   task automatic test_discard();
      logic [5:0] exp_d = 6'b001110; // bit c = cycle c
      for (int c = 0; c < 6; c++) begin
         idle(); branch = (c == 0);
         #1;
         vectors++;
         if (discard !== exp_d[c]) begin
            miscompares++; $display("FAIL discard_single c=%0d got=%b exp=%b", c, discard, exp_d[c]);
         end
         step();
      end
   endtask

   task automatic test_discard_reload();
      logic [7:0] exp_d = 8'b00111110;
      for (int c = 0; c < 8; c++) begin
         idle(); branch = (c == 0 || c == 2);
         #1;
         vectors++;
         if (discard !== exp_d[c]) begin
            miscompares++; $display("FAIL discard_reload c=%0d got=%b exp=%b", c, discard, exp_d[c]);
         end
         step();
      end
   endtask

   task automatic test_load_use(input bit via_rs1);
      logic [3:0] exp_s = 4'b0011;
      for (int c = 0; c < 4; c++) begin
         idle();
         if (c == 0) begin
            if (via_rs1) begin ex_load = 1; ex_rd = 17; rs1 = 17; rs1_used = 1; rs2 = 2; rs2_used = 1; end
            else hazard_rs2();
         end
         #1;
         vectors++;
         if (stall !== exp_s[c] || bubble !== exp_s[c]) begin
            miscompares++;
            $display("FAIL load_use rs1=%0b c=%0d got=%b/%b exp=%b", via_rs1, c, stall, bubble, exp_s[c]);
         end
         step();
      end
   endtask

   task automatic test_no_stall();
      for (int c = 0; c < 6; c++) begin
         idle(); ex_load = 1; rs1 = 5; rs2 = 5;
         if (c < 3) begin ex_rd = 0; rs1 = 0; rs2 = 0; rs1_used = 1; rs2_used = 1; end
         else begin ex_rd = 5; rs1_used = 0; rs2_used = 0; end
         #1;
         vectors++;
         if (stall !== 1'b0 || bubble !== 1'b0) begin
            miscompares++; $display("FAIL no_stall c=%0d got=%b/%b exp=0", c, stall, bubble);
         end
         step();
      end
      idle(); step();
   endtask

   task automatic test_trap_loaduse();
      logic [4:0] exp_d = 5'b01110;
      for (int c = 0; c < 5; c++) begin
         idle();
         if (c < 4) hazard_rs2();
         trap = (c == 0);
         #1;
         vectors++;
         if (stall !== 1'b0) begin
            miscompares++; $display("FAIL trap_lu_stall c=%0d got=%b exp=0", c, stall);
         end
         vectors++;
         if (discard !== exp_d[c]) begin
            miscompares++; $display("FAIL trap_lu_discard c=%0d got=%b exp=%b", c, discard, exp_d[c]);
         end
         step();
      end
   endtask

   task automatic test_stall_cut();
      logic [5:0] exp_s = 6'b000001;
      logic [5:0] exp_d = 6'b011100;
      for (int c = 0; c < 6; c++) begin
         idle();
         if (c == 0) hazard_rs2();
         branch = (c == 1);
         #1;
         vectors++;
         if (stall !== exp_s[c] || discard !== exp_d[c]) begin
            miscompares++;
            $display("FAIL stall_cut c=%0d got=%b/%b exp=%b/%b", c, stall, discard, exp_s[c], exp_d[c]);
         end
         step();
      end
   endtask

   task automatic test_reset_mid();
      idle(); branch = 1; step();
      idle(); #1;
      vectors++;
      if (discard !== 1'b1) begin miscompares++; $display("FAIL mid_pre_discard got=%b exp=1", discard); end
      rst = 1; step();
      rst = 0; #1;
      vectors++;
      if (discard !== 1'b0) begin miscompares++; $display("FAIL mid_reset_discard got=%b exp=0", discard); end
      step();
      hazard_rs2(); #1;
      vectors++;
      if (stall !== 1'b1) begin miscompares++; $display("FAIL mid_pre_stall got=%b exp=1", stall); end
      rst = 1; step();
      idle(); rst = 0; #1;
      vectors++;
      if (stall !== 1'b0 || discard !== 1'b0) begin
         miscompares++; $display("FAIL mid_reset_stall got=%b/%b exp=0/0", stall, discard);
      end
      step();
   endtask

`ifdef HAZARD_PERF_CTR_EN
   task automatic test_perf();
      idle(); rst = 1; step(); rst = 0;
      hazard_rs2(); step();
      idle(); step(); step();
      branch = 1; step();
      idle();
      for (int c = 0; c < 6; c++) step();
      vectors++;
      if (stall_cnt !== 32'(LL)) begin miscompares++; $display("FAIL perf_stall got=%0d exp=%0d", stall_cnt, LL); end
      vectors++;
      if (discard_cnt !== 32'(DD)) begin miscompares++; $display("FAIL perf_discard got=%0d exp=%0d", discard_cnt, DD); end
   endtask
`endif

   initial begin
      test_reset();
      test_discard();
      test_discard_reload();
      test_load_use(1'b0);
      test_load_use(1'b1);
      test_no_stall();
      test_trap_loaduse();
      test_stall_cut();
      test_reset_mid();
`ifdef HAZARD_PERF_CTR_EN
      test_perf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the ECAP5-DPROC core: generalises control-hazard discard to a configurable depth, adds trap-driven flushes and load-use data-hazard stalling, and optionally counts hazard cycles. Sits beside the pipeline stages, takes redirect and register-usage information from decode/execute, and drives the stall, bubble and discard controls back into fetch, decode and execute.

## Interface
Parameters:
- DISCARD_DEPTH, 2, number of cycles control_discard_o stays high after a redirect (range 1..7)
- LOAD_LATENCY, 1, number of stall cycles for a load-use hazard (range 1..7)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- branch_i  in  1  taken branch/jump resolved in execute this cycle
- trap_i  in  1  exception/interrupt redirect this cycle
- dec_rs1_i  in  5  decode-stage rs1 address
- dec_rs2_i  in  5  decode-stage rs2 address
- dec_rs1_used_i  in  1  decode instruction reads rs1
- dec_rs2_used_i  in  1  decode instruction reads rs2
- ex_rd_i  in  5  execute-stage destination register
- ex_load_i  in  1  execute stage holds a valid load
- stall_o  out  1  hold fetch and decode registers
- bubble_o  out  1  inject NOP into execute
- control_discard_o  out  1  younger in-flight instructions must be discarded
- stall_cnt_o  out  32  cycles with stall_o high (only with HAZARD_PERF_CTR_EN)
- discard_cnt_o  out  32  cycles with control_discard_o high (only with HAZARD_PERF_CTR_EN)

## Operation
- redirect = branch_i | trap_i.
- Discard counter discard_ctr_q, width $clog2(DISCARD_DEPTH+1): loaded with DISCARD_DEPTH on redirect; else decremented while nonzero; else holds 0. control_discard_o = (discard_ctr_q != 0).
- Redirect while counter nonzero reloads to DISCARD_DEPTH (no accumulation).
- Load-use detect (comb): lu = ex_load_i & (ex_rd_i != 0) & ((dec_rs1_used_i & dec_rs1_i == ex_rd_i) | (dec_rs2_used_i & dec_rs2_i == ex_rd_i)); qualified lu_q = lu & ~control_discard_o & ~redirect.
- Stall counter stall_ctr_q, width $clog2(LOAD_LATENCY): on lu_q with stall_ctr_q == 0 load LOAD_LATENCY-1; else decrement while nonzero.
- stall_o = bubble_o = (lu_q | stall_ctr_q != 0) & ~redirect & ~control_discard_o.
- Redirect or active discard clears stall_ctr_q to 0 next cycle (stalled instruction is being discarded).
- x0 as ex_rd_i never causes a stall.

## Timing
- Reset: discard_ctr_q = 0, stall_ctr_q = 0, so control_discard_o = 0, stall_o = 0, bubble_o = 0, counters = 0.
- Redirect in cycle N: control_discard_o high cycles N+1..N+DISCARD_DEPTH; stall_o forced low in N.
- Load-use in cycle N: stall_o/bubble_o high same cycle N (combinational) and cycles N+1..N+LOAD_LATENCY-1; low at N+LOAD_LATENCY.
- Redirect and load-use same cycle: redirect wins, no stall.
- rst_i mid-discard or mid-stall: all state to reset values on next edge, outputs low thereafter.

## Configuration
- HAZARD_PERF_CTR_EN defined: stall_cnt_o and discard_cnt_o present; each increments by 1 on every cycle its output is high, wraps modulo 2^32, reset to 0.
- Not defined: both ports and counters absent; no other behaviour changes.

## Structure
- ecap5_dproc_pkg: constant REG_ADDR_W = 5 and the x0 address constant; no new typedefs required.
- One natural sub-module: hazard_down_ctr (loadable saturating-at-zero down counter, parametrised width), instantiated twice for discard and stall counters.
- Perf counters inline, guarded by the macro.

## Test plan
- Reset with branch_i = 1 asserted during reset -> control_discard_o, stall_o, bubble_o all 0 on first post-reset cycle.
- DISCARD_DEPTH=3, branch_i pulse at cycle 10 -> control_discard_o high cycles 11,12,13, low at 14; second pulse at 12 -> high through 15.
- LOAD_LATENCY=2, ex_load_i=1, ex_rd_i=5, dec_rs2_i=5, dec_rs2_used_i=1 at cycle 20 -> stall_o/bubble_o high cycles 20,21, low 22.
- Same as above with ex_rd_i=0, or dec_rs2_used_i=0 -> stall_o never asserts.
- Load-use at cycle 30 with trap_i=1 same cycle -> stall_o 0 at 30, control_discard_o high 31..30+DISCARD_DEPTH.
- HAZARD_PERF_CTR_EN, preload-free run: 1 stall cycle and one DISCARD_DEPTH=2 discard -> stall_cnt_o=1, discard_cnt_o=2.
